heart_lives_renderer: RTL



---
 rtl/heart_pkg.sv | 20 ++
 rtl/lives_fsm.sv | 114 +++++++++++
 rtl/heart_lives_renderer.sv | 117 +++++++++++
 3 files changed

// File: rtl/heart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : heart_pkg                                               |
// | Purpose  : Shared types and sizes for the lives heart overlay.     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package heart_pkg;

    localparam int HEART_SIZE    = 16;
    localparam int SPRITE_ADDR_W = 4;
    localparam int PIX_W         = 10;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } lives_state_t;

endpackage
`default_nettype wire

// File: rtl/lives_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : lives_fsm                                               |
// | Purpose  : Lives counter and invulnerability/blink state machine.  |
// |            LIVES_BLINK_EN enables heart blanking while invulnerable|
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module lives_fsm
    import heart_pkg::*;
#(
    parameter int  MAX_LIVES    = 3,
    parameter int  BLINK_FRAMES = 60,
    parameter int  BLINK_SHIFT  = 3,
    localparam int LIVES_W      = $clog2(MAX_LIVES + 1),
    localparam int CNT_W        = $clog2(BLINK_FRAMES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               hit,
    input  logic               heal,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               invuln,
    output logic               game_over,
    output logic               blank
);

    localparam logic [LIVES_W-1:0] c_max_lives    = LIVES_W'(MAX_LIVES);
    localparam logic [CNT_W-1:0]   c_blink_frames = CNT_W'(BLINK_FRAMES);

    lives_state_t       r_state;
    lives_state_t       w_state_nxt;
    logic [LIVES_W-1:0] r_lives;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic [CNT_W-1:0]   r_blink_cnt;
    logic [CNT_W-1:0]   w_blink_cnt_nxt;
    logic [LIVES_W-1:0] w_lives_inc;
    logic [LIVES_W-1:0] w_lives_dec;

    assign w_lives_dec = r_lives - LIVES_W'(1);
    assign w_lives_inc = (r_lives >= c_max_lives) ? c_max_lives : r_lives + LIVES_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ALIVE;
            r_lives     <= c_max_lives;
            r_blink_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
        end
    end

    // restart overrides everything; a hit while ALIVE swallows a same-cycle heal
    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_blink_cnt_nxt = r_blink_cnt;
        if (restart) begin
            w_state_nxt     = ALIVE;
            w_lives_nxt     = c_max_lives;
            w_blink_cnt_nxt = '0;
        end else begin
            case (r_state)
                ALIVE: begin
                    if (hit) begin
                        w_lives_nxt = w_lives_dec;
                        if (w_lives_dec == '0) begin
                            w_state_nxt = DEAD;
                        end else begin
                            w_state_nxt     = INVULN;
                            w_blink_cnt_nxt = c_blink_frames;
                        end
                    end else if (heal) begin
                        w_lives_nxt = w_lives_inc;
                    end
                end
                INVULN: begin
                    if (heal) begin
                        w_lives_nxt = w_lives_inc;
                    end
                    if (frame_tick) begin
                        if (r_blink_cnt <= CNT_W'(1)) begin
                            w_blink_cnt_nxt = '0;
                            w_state_nxt     = ALIVE;
                        end else begin
                            w_blink_cnt_nxt = r_blink_cnt - CNT_W'(1);
                        end
                    end
                end
                DEAD: begin
                    w_lives_nxt = '0;
                end
                default: begin
                    w_state_nxt = ALIVE;
                end
            endcase
        end
    end

    assign lives     = r_lives;
    assign invuln    = (r_state == INVULN);
    assign game_over = (r_state == DEAD);

`ifdef LIVES_BLINK_EN
    assign blank = (r_state == DEAD) || ((r_state == INVULN) && r_blink_cnt[BLINK_SHIFT]);
`else
    assign blank = (r_state == DEAD);
`endif

endmodule
`default_nettype wire

// File: rtl/heart_lives_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : heart_lives_renderer                                    |
// | Purpose  : Row of lives hearts from a 16x16 sprite ROM, 2-clk      |
// |            overlay pipeline. LIVES_BLINK_EN selects blinking.      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module heart_lives_renderer
    import heart_pkg::*;
#(
    parameter int  MAX_LIVES    = 3,
    parameter int  X_ORIGIN     = 16,
    parameter int  Y_ORIGIN     = 16,
    parameter int  SPACING      = 20,
    parameter int  BLINK_FRAMES = 60,
    parameter int  BLINK_SHIFT  = 3,
    localparam int LIVES_W      = $clog2(MAX_LIVES + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PIX_W-1:0]         x,
    input  logic [PIX_W-1:0]         y,
    input  logic                     video_on,
    input  logic                     frame_tick,
    input  logic                     hit,
    input  logic                     heal,
    input  logic                     restart,
    output logic [SPRITE_ADDR_W-1:0] rom_row,
    output logic [SPRITE_ADDR_W-1:0] rom_col,
    input  logic                     rom_data,
    output logic                     heart_on,
    output logic [LIVES_W-1:0]       lives,
    output logic                     invuln,
    output logic                     game_over
);

    // One extra bit keeps slot-edge arithmetic from wrapping near the right screen edge
    localparam int                   c_coord_w = PIX_W + 1;
    localparam logic [c_coord_w-1:0] c_size    = c_coord_w'(HEART_SIZE);
    localparam logic [c_coord_w-1:0] c_y_lo    = c_coord_w'(Y_ORIGIN);

    logic [c_coord_w-1:0]     w_x_ext;
    logic [c_coord_w-1:0]     w_y_ext;
    logic                     w_in_y;
    logic [SPRITE_ADDR_W-1:0] w_row_off;
    logic [MAX_LIVES-1:0]     w_slot_in;
    logic [MAX_LIVES-1:0]     w_slot_live;
    logic [SPRITE_ADDR_W-1:0] w_slot_col [MAX_LIVES];
    logic                     w_in_region;
    logic [SPRITE_ADDR_W-1:0] w_col;
    logic                     w_draw_en;
    logic                     w_blank;
    logic                     r_draw_en_d1;
    logic                     r_heart_on;

    assign w_x_ext   = {1'b0, x};
    assign w_y_ext   = {1'b0, y};
    assign w_in_y    = (w_y_ext >= c_y_lo) && (w_y_ext < c_y_lo + c_size);
    assign w_row_off = SPRITE_ADDR_W'(w_y_ext - c_y_lo);

    generate
        for (genvar k = 0; k < MAX_LIVES; k++) begin : g_slot
            localparam logic [c_coord_w-1:0] c_base = c_coord_w'(X_ORIGIN + k * SPACING);
            localparam logic [LIVES_W-1:0]   c_idx  = LIVES_W'(k);
            assign w_slot_in[k]   = w_in_y && (w_x_ext >= c_base) && (w_x_ext < c_base + c_size);
            assign w_slot_live[k] = (c_idx < lives);
            assign w_slot_col[k]  = SPRITE_ADDR_W'(w_x_ext - c_base);
        end
    endgenerate

    // Slots never overlap, so at most one bit of w_slot_in is set
    always_comb begin
        w_in_region = 1'b0;
        w_col       = '0;
        for (int k = 0; k < MAX_LIVES; k++) begin
            if (w_slot_in[k]) begin
                w_in_region = 1'b1;
                w_col       = w_slot_col[k];
            end
        end
    end

    assign rom_row   = w_in_region ? w_row_off : '0;
    assign rom_col   = w_in_region ? w_col : '0;
    assign w_draw_en = (|(w_slot_in & w_slot_live)) & video_on & ~w_blank;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_draw_en_d1 <= 1'b0;
            r_heart_on   <= 1'b0;
        end else begin
            r_draw_en_d1 <= w_draw_en;
            r_heart_on   <= r_draw_en_d1 & ~rom_data;
        end
    end

    assign heart_on = r_heart_on;

    lives_fsm #(
        .MAX_LIVES    (MAX_LIVES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_SHIFT  (BLINK_SHIFT)
    ) u_lives_fsm (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .hit        (hit),
        .heal       (heal),
        .restart    (restart),
        .lives      (lives),
        .invuln     (invuln),
        .game_over  (game_over),
        .blank      (w_blank)
    );

endmodule
`default_nettype wire
